// File: rtl/press_counter_7seg.sv
// ============================================================================
// press_counter_7seg : press detector with auto-repeat, 00-99 BCD counter, 7-seg
// Revision 1.0
// ============================================================================
`default_nettype none

module press_counter_7seg #(
    parameter int c_Hold_Cycles   = 12500000,
    parameter int c_Repeat_Cycles = 2500000,
    parameter int c_Timer_Width   = 24
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch,
    input  logic       i_Clear,
    output logic [7:0] o_Count,
    output logic       o_Pulse,
    output logic [6:0] o_Seg_Tens,
    output logic [6:0] o_Seg_Ones
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HOLD   = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    localparam logic [c_Timer_Width-1:0] c_HOLD_LAST   = c_Timer_Width'(c_Hold_Cycles - 1);
    localparam logic [c_Timer_Width-1:0] c_REPEAT_LAST = c_Timer_Width'(c_Repeat_Cycles - 1);
    localparam logic [c_Timer_Width-1:0] c_TIMER_ONE   = c_Timer_Width'(1);

    logic [1:0]               r_State;
    logic [c_Timer_Width-1:0] r_Timer;
    logic                     r_Sw_Q;
    logic [7:0]               r_Count;
    logic                     r_Pulse;
    logic [6:0]               r_Seg_Tens;
    logic [6:0]               r_Seg_Ones;

    logic [1:0]               w_State_Nxt;
    logic [c_Timer_Width-1:0] w_Timer_Nxt;
    logic                     w_Inc;
    logic                     w_Press;
    logic [7:0]               w_Count_Inc;
    logic [6:0]               w_Seg_Tens;
    logic [6:0]               w_Seg_Ones;

    function automatic logic [6:0] f_Decode(input logic [3:0] i_Bcd);
        case (i_Bcd)
            4'd0:    f_Decode = 7'b1000000;
            4'd1:    f_Decode = 7'b1111001;
            4'd2:    f_Decode = 7'b0100100;
            4'd3:    f_Decode = 7'b0110000;
            4'd4:    f_Decode = 7'b0011001;
            4'd5:    f_Decode = 7'b0010010;
            4'd6:    f_Decode = 7'b0000010;
            4'd7:    f_Decode = 7'b1111000;
            4'd8:    f_Decode = 7'b0000000;
            4'd9:    f_Decode = 7'b0010000;
            default: f_Decode = 7'b1111111;
        endcase
    endfunction

    assign w_Press = i_Switch & ~r_Sw_Q;

    // State register; count, pulse and segment decodes are registered alongside
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State    <= c_ST_IDLE;
            r_Timer    <= '0;
            r_Sw_Q     <= 1'b0;
            r_Count    <= 8'h00;
            r_Pulse    <= 1'b0;
            r_Seg_Tens <= 7'b1000000;
            r_Seg_Ones <= 7'b1000000;
        end else begin
            r_State    <= w_State_Nxt;
            r_Timer    <= w_Timer_Nxt;
            r_Sw_Q     <= i_Switch;
            r_Pulse    <= w_Inc;
            r_Seg_Tens <= w_Seg_Tens;
            r_Seg_Ones <= w_Seg_Ones;
            if (i_Clear) begin
                r_Count <= 8'h00;
            end else if (w_Inc) begin
                r_Count <= w_Count_Inc;
            end
        end
    end

    // Release is checked before timer expiry so a drop on the expiry cycle never counts
    always_comb begin
        w_State_Nxt = r_State;
        w_Timer_Nxt = r_Timer;
        w_Inc       = 1'b0;
        case (r_State)
            c_ST_IDLE: begin
                if (w_Press) begin
                    w_Inc       = 1'b1;
                    w_Timer_Nxt = '0;
                    w_State_Nxt = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (!i_Switch) begin
                    w_State_Nxt = c_ST_IDLE;
                    w_Timer_Nxt = '0;
                end else if (r_Timer == c_HOLD_LAST) begin
                    w_Inc       = 1'b1;
                    w_Timer_Nxt = '0;
                    w_State_Nxt = c_ST_REPEAT;
                end else begin
                    w_Timer_Nxt = r_Timer + c_TIMER_ONE;
                end
            end
            c_ST_REPEAT: begin
                if (!i_Switch) begin
                    w_State_Nxt = c_ST_IDLE;
                    w_Timer_Nxt = '0;
                end else if (r_Timer == c_REPEAT_LAST) begin
                    w_Inc       = 1'b1;
                    w_Timer_Nxt = '0;
                end else begin
                    w_Timer_Nxt = r_Timer + c_TIMER_ONE;
                end
            end
            default: begin
                w_State_Nxt = c_ST_IDLE;
                w_Timer_Nxt = '0;
            end
        endcase
        if (i_Clear) begin
            w_State_Nxt = c_ST_IDLE;
            w_Timer_Nxt = '0;
            w_Inc       = 1'b0;
        end
    end

    always_comb begin
        w_Count_Inc = r_Count;
        if (r_Count[3:0] == 4'd9) begin
            w_Count_Inc[3:0] = 4'd0;
            w_Count_Inc[7:4] = (r_Count[7:4] == 4'd9) ? 4'd0 : r_Count[7:4] + 4'd1;
        end else begin
            w_Count_Inc[3:0] = r_Count[3:0] + 4'd1;
        end
        w_Seg_Tens = f_Decode(r_Count[7:4]);
        w_Seg_Ones = f_Decode(r_Count[3:0]);
    end

    assign o_Count    = r_Count;
    assign o_Pulse    = r_Pulse;
    assign o_Seg_Tens = r_Seg_Tens;
    assign o_Seg_Ones = r_Seg_Ones;

endmodule

`default_nettype wire

// File: doc/press_counter_7seg.md
Name: press_counter_7seg

Overview:
- Consumes the debounced switch level produced by the debounce stage.
- Detects presses, with auto-repeat while the switch is held.
- Maintains a two-digit BCD count 00–99 and drives two active-low 7-segment digit outputs.
- Sits between the debounce stage and the board's two 7-segment displays.

Parameters:
c_Hold_Cycles, 12500000, cycles the switch must stay held after a press before auto-repeat starts (500 ms at 25 MHz); legal range >= 2
c_Repeat_Cycles, 2500000, cycles between auto-repeat increments while held (100 ms at 25 MHz); legal range >= 2
c_Timer_Width, 24, width of the internal hold/repeat timer; must hold max(c_Hold_Cycles, c_Repeat_Cycles)

Ports:
i_Clk  input  1  system clock, 25 MHz
i_Rst_L  input  1  asynchronous active-low reset
i_Switch  input  1  debounced switch level, already synchronous to i_Clk; 1 = pressed
i_Clear  input  1  synchronous clear of count to 00
o_Count  output  8  BCD count, [7:4] tens, [3:0] ones
o_Pulse  output  1  one-cycle strobe on every increment
o_Seg_Tens  output  7  tens digit segments, active-low, bit order {G,F,E,D,C,B,A}
o_Seg_Ones  output  7  ones digit segments, active-low, bit order {G,F,E,D,C,B,A}

Behaviour:
- Reset (i_Rst_L=0, asynchronous) forces the following:
  - state IDLE, timer 0, r_Sw_Q 0
  - o_Count 8'h00, o_Pulse 0
  - o_Seg_Tens = o_Seg_Ones = 7'b1000000 (digit "0")
- Reset release is synchronous in effect: the first active edge after deassertion operates normally.
- Edge detect: r_Sw_Q registers i_Switch every cycle. A press is i_Switch=1 and r_Sw_Q=0, evaluated combinationally, and acted on at the same edge.
- State machine:
  - IDLE: on press → increment, timer<=0, go HOLD.
  - HOLD: if i_Switch=0 → IDLE, timer<=0. Else if timer==c_Hold_Cycles-1 → increment, timer<=0, go REPEAT. Else timer+1.
  - REPEAT: if i_Switch=0 → IDLE, timer<=0. Else if timer==c_Repeat_Cycles-1 → increment, timer<=0. Else timer+1.
- Release takes priority over a timer expiry in the same cycle: no increment, go IDLE.
- Increment:
  - ones 0–8 → ones+1.
  - ones 9 → ones 0, tens+1.
  - 99 → 00 (wrap); o_Pulse still fires.
- o_Pulse=1 for exactly the cycle following each increment edge, i.e. it is registered alongside o_Count.
- i_Clear=1:
  - o_Count<=00, state<=IDLE, timer<=0, o_Pulse<=0.
  - Overrides any increment that cycle.
  - A press coincident with clear is discarded. r_Sw_Q still updates, so a held switch does not re-trigger after clear is removed.
- Latency:
  - o_Count updates at the same edge the press is sampled.
  - o_Seg_* are registered decodes of o_Count and lag it by 1 cycle.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. BCD values 10–15 are unreachable; decode them to 7'b1111111 (blank).
- No leading-zero blanking: tens shows "0" for counts below 10.
- Timer is not advanced in IDLE.

Test Plan:
- Reset mid-count: hold i_Rst_L low for 3 cycles with count 8'h37 → asynchronously o_Count=00, both seg=1000000, o_Pulse=0. First press after release → o_Count=01.
- Single press (c_Hold_Cycles=10, c_Repeat_Cycles=4): i_Switch high 5 cycles, then low → exactly one o_Pulse, o_Count=01. o_Seg_Ones=1111001 one cycle after o_Count changes.
- Auto-repeat (same params): hold i_Switch high 30 cycles → increments at press edge, press+10, then every 4 cycles (press+14, +18, +22, +26). o_Count=06, 6 pulses. Release → IDLE, no further increments.
- Carry and wrap: start at 09, press → 10 (tens seg 1111001, ones seg 1000000). Force to 99, press → 00 with o_Pulse=1.
- Clear vs press: assert i_Clear in the same cycle as the press rising edge while count=42 → o_Count=00, no pulse. Switch held afterwards with i_Clear low → no increment until release and re-press.
- Release at expiry: drop i_Switch on the exact cycle the timer reaches c_Hold_Cycles-1 → no increment, state IDLE. Next press increments normally.
